contador_palabras: RTL and testbench
====================================

// Module: contador_palabras
// PURPOSE
//  Word-count responder for the 4x4 FIFO switch. Counts successful pops on output FIFOs 4..7.
//  Answers the probe-side request (IDLE, req, idx) with a registered count (contador_out) and
//  a qualifier (valid_contador). Sits beside the output FIFOs and taps their pop and empty lines.
// PARAMETERS
//  N_FIFO   4   number of output FIFOs counted; idx width is clog2(N_FIFO)
//  CNT_W    5   counter width; also the contador_out width
// PORTS
//  clk             in   1      single clock; all state is updated on the rising edge
//  reset           in   1      asynchronous, active-low; 0 clears all state immediately
//  pop4..pop7      in   1 ea   pop strobes presented to output FIFOs 4..7
//  empty4..empty7  in   1 ea   empty flags of output FIFOs 4..7
//  IDLE            in   1      switch FSM is in IDLE; reads are honoured only while high
//  req             in   1      read request; level-sensitive, sampled every cycle
//  idx             in   2      counter index to read (0 -> FIFO4 ... 3 -> FIFO7)
//  valid_contador  out  1      contador_out holds a valid answer this cycle
//  contador_out    out  CNT_W  count for the requested idx
// BEHAVIOUR
//  Reset (reset=0, asynchronous)
//   - cnt[0..3]=0, valid_contador=0, contador_out=0, FSM -> ESPERA
//   - overrides any request in flight; the outputs drop in the same time step
//   - counting and answering restart on the first rising clk edge after reset returns to 1
//  Counting, every rising edge
//   - pop_ok[i] = pop(4+i) & ~empty(4+i)
//   - when pop_ok[i]=1: cnt[i] <= cnt[i]+1, modulo 2^CNT_W (31 -> 0), no saturation
//   - a pop while the FIFO is empty is not counted
//   - all four counters update independently; simultaneous pops are all counted
//   - counting runs regardless of the IDLE, req and FSM state
//  Read FSM (2 states, registered)
//   - ESPERA:
//     - valid_contador=0, contador_out=0
//     - if req&IDLE at the edge: go to RESPONDE, contador_out <= cnt[idx], valid_contador <= 1
//   - RESPONDE:
//     - while req&IDLE: re-sample idx every edge; contador_out <= cnt[idx]
//       (idx sweep 0,1,2,3 on consecutive cycles gives 4 answers, each 1 cycle late)
//     - if ~(req&IDLE) at the edge: go to ESPERA, valid_contador <= 0, contador_out <= 0
//  Latency: exactly 1 cycle from sampling req&IDLE&idx to valid output
//  Same-edge read and pop on one counter: the answer is the pre-increment value. A pop at
//   edge k shows up in a read sampled at edge k+1 or later.
//  idx is 2 bits, so every value maps to a counter and no out-of-range case exists.
//  IDLE falling while req=1 ends the answer on the next edge, the same as req falling.
// STRUCTURE
//  Shared package (switch_pkg):
//   - N_FIFO, CNT_W
//   - read-FSM state enum {ESPERA, RESPONDE}
//   - IDX_W = clog2(N_FIFO)
//  Sub-module contador_canal, instanced N_FIFO times:
//   - one CNT_W counter with async active-low reset
//   - inc = pop & ~empty
//  Top: pop_ok generation, 4:1 count mux on idx, read FSM, output registers
// TESTING
//  1 Reset: assert reset=0 mid-run -> valid_contador=0, contador_out=0 at once; later reads return 0.
//  2 Count: 3 pops on pop4 with empty4=0, then IDLE=1,req=1,idx=0 -> next cycle valid=1, out=3.
//  3 Empty pop: pop5=1 for 2 cycles with empty5=1 -> idx=1 read returns 0.
//  4 Sweep: counts {4,4,4,4} preloaded by pops; req=1,IDLE=1, idx=0,1,2,3 on consecutive cycles
//    -> out=4,4,4,4 one cycle behind; valid high 4 cycles; drops 1 cycle after req=0.
//  5 Wrap and same-edge: 33 pops on pop6 -> idx=2 reads 1.
//    Pop7 on the edge idx=3 is sampled -> pre-increment value; the next read shows +1.
//  6 Gating: req=1 with IDLE=0 for 5 cycles -> valid stays 0;
//    raise IDLE -> valid=1 on the next edge.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the 4x4 FIFO switch: counter sizing and the
// word-count read FSM states.
package switch_pkg;

  localparam int N_FIFO = 4;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = $clog2(N_FIFO);

  typedef enum logic {
    ESPERA,
    RESPONDE
  } estado_t;

endpackage

// File: rtl/contador_canal.sv
// Per-FIFO pop counter: increments on a pop that actually removes a word,
// wrapping modulo 2^CNT_W.
module contador_canal
  import switch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pop,
  input  logic             empty,
  output logic [CNT_W-1:0] cnt
);

  logic inc;

  assign inc = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/contador_palabras.sv
// Word-count responder: counts successful pops on output FIFOs 4..7 and
// answers probe reads (req & IDLE, idx) with a registered count one cycle later.
module contador_palabras
  import switch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pop4,
  input  logic             pop5,
  input  logic             pop6,
  input  logic             pop7,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  input  logic             IDLE,
  input  logic             req,
  input  logic [IDX_W-1:0] idx,
  output logic             valid_contador,
  output logic [CNT_W-1:0] contador_out
);

  logic [N_FIFO-1:0] pop_v;
  logic [N_FIFO-1:0] empty_v;
  logic [CNT_W-1:0]  cnt [N_FIFO];

  assign pop_v   = {pop7, pop6, pop5, pop4};
  assign empty_v = {empty7, empty6, empty5, empty4};

  for (genvar g = 0; g < N_FIFO; g++) begin : g_canal
    contador_canal u_canal (
      .clk   (clk),
      .reset (reset),
      .pop   (pop_v[g]),
      .empty (empty_v[g]),
      .cnt   (cnt[g])
    );
  end

  estado_t          state;
  estado_t          next_state;
  logic             lectura;
  logic             valid_next;
  logic [CNT_W-1:0] out_next;

  assign lectura = req & IDLE;

  // The count mux reads the pre-increment value, so a same-edge pop is not seen.
  always_comb begin
    next_state = state;
    valid_next = 1'b0;
    out_next   = '0;
    case (state)
      ESPERA: begin
        if (lectura) begin
          next_state = RESPONDE;
          valid_next = 1'b1;
          out_next   = cnt[idx];
        end
      end
      RESPONDE: begin
        if (lectura) begin
          valid_next = 1'b1;
          out_next   = cnt[idx];
        end else begin
          next_state = ESPERA;
        end
      end
      default: next_state = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ESPERA;
      valid_contador <= 1'b0;
      contador_out   <= '0;
    end else begin
      state          <= next_state;
      valid_contador <= valid_next;
      contador_out   <= out_next;
    end
  end

endmodule

// File: tb/tb_contador_palabras.sv
// Scoreboard bench for contador_palabras: a reference model queues expected
// answers per read; an independent monitor checks every cycle of output.
module tb_contador_palabras;
  import switch_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       pop_v = '0;
  logic [3:0]       empty_v = '0;
  logic             IDLE = 1'b0;
  logic             req = 1'b0;
  logic [IDX_W-1:0] idx = '0;
  logic             valid_contador;
  logic [CNT_W-1:0] contador_out;

  int model_cnt [4] = '{0, 0, 0, 0};
  int exp_q [$];
  int checks = 0;
  int fails  = 0;

  contador_palabras dut (
    .clk            (clk),
    .reset          (reset),
    .pop4           (pop_v[0]),
    .pop5           (pop_v[1]),
    .pop6           (pop_v[2]),
    .pop7           (pop_v[3]),
    .empty4         (empty_v[0]),
    .empty5         (empty_v[1]),
    .empty6         (empty_v[2]),
    .empty7         (empty_v[3]),
    .IDLE           (IDLE),
    .req            (req),
    .idx            (idx),
    .valid_contador (valid_contador),
    .contador_out   (contador_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a read sees the counts before this edge's pops land.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) model_cnt[i] = 0;
      exp_q.delete();
    end else begin
      if (req === 1'b1 && IDLE === 1'b1) exp_q.push_back(model_cnt[idx]);
      for (int i = 0; i < 4; i++)
        if (pop_v[i] && !empty_v[i]) model_cnt[i] = (model_cnt[i] + 1) % 32;
    end
  end

  always @(posedge clk) begin
    #1;
    if (valid_contador === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 1, 0);
      end else begin
        check_output("contador_out", int'(contador_out), exp_q.pop_front());
      end
    end else begin
      check_output("valid_contador", int'(valid_contador), exp_q.size() != 0 ? 1 : 0);
      check_output("idle_out_zero", int'(contador_out), 0);
      exp_q.delete();
    end
  end

  task automatic apply_stimulus(input logic [3:0] p, input logic [3:0] e,
                                input logic i, input logic r, input logic [1:0] x);
    @(negedge clk);
    pop_v   = p;
    empty_v = e;
    IDLE    = i;
    req     = r;
    idx     = x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Count: three good pops on FIFO4, then read idx 0
    repeat (3) apply_stimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Empty pops on FIFO5 are ignored
    repeat (2) apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset in the middle of an answer
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_valid", int'(valid_contador), 0);
    check_output("reset_out", int'(contador_out), 0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Sweep: four pops on every FIFO, then idx 0..3 back to back
    repeat (4) apply_stimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'(k));
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Wrap on FIFO6 and same-edge pop/read on FIFO7
    do_reset();
    repeat (33) apply_stimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2);
    apply_stimulus(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Gating: req without IDLE is ignored until IDLE rises
    repeat (5) apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);
    apply_stimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) != 0), 2'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
